// File: rtl/calculator_entry_fsm.sv
// Keypad entry controller: builds two decimal operands and a one-hot operator from key strobes,
// then holds them while the downstream calculation stage's answer is displayed.
module calculator_entry_fsm #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        IN_clk,
  input  logic        IN_reset_n,
  input  logic        IN_key_valid,
  input  logic [3:0]  IN_key_code,
  input  logic [31:0] IN_answer,
  input  logic        IN_is_negative,
  output logic [15:0] OUT_num1,
  output logic [15:0] OUT_num2,
  output logic [2:0]  OUT_operation_code,
  output logic        OUT_show_answer,
  output logic        OUT_entering_b,
  output logic        OUT_key_rejected
);

  localparam logic [2:0] MAX_CNT    = 3'(MAX_DIGITS);
  localparam logic [3:0] KEY_EQUALS = 4'd13;
  localparam logic [3:0] KEY_CLEAR  = 4'd14;
  localparam logic [3:0] KEY_BKSP   = 4'd15;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  typedef struct packed {
    logic        ok;
    logic [15:0] val;
    logic [2:0]  cnt;
  } acc_t;

  state_t      state, state_nxt;
  logic [15:0] num1, num1_nxt, num2, num2_nxt;
  logic [2:0]  op, op_nxt;
  logic [2:0]  cnt_a, cnt_a_nxt, cnt_b, cnt_b_nxt;
  logic        rejected, rej_nxt;
  logic        is_digit, is_op;
  acc_t        acc_a, acc_b;

  // A lone leading zero is replaced by the next digit rather than shifted, so it never counts twice.
  function automatic acc_t accumulate(input logic [15:0] cur, input logic [2:0] cnt,
                                      input logic [3:0] d);
    acc_t        res;
    logic [19:0] wide;
    wide    = ({4'd0, cur} * 20'd10) + {16'd0, d};
    res.ok  = 1'b0;
    res.val = cur;
    res.cnt = cnt;
    if (cur == 16'd0 && cnt == 3'd1) begin
      if (d != 4'd0) begin
        res.ok  = 1'b1;
        res.val = {12'd0, d};
      end
    end else if (cnt < MAX_CNT && wide <= 20'd65535) begin
      res.ok  = 1'b1;
      res.val = wide[15:0];
      res.cnt = cnt + 3'd1;
    end
    return res;
  endfunction

  function automatic logic [2:0] op_onehot(input logic [3:0] code);
    case (code)
      4'd10:   op_onehot = 3'b001;
      4'd11:   op_onehot = 3'b010;
      default: op_onehot = 3'b100;
    endcase
  endfunction

  always_ff @(posedge IN_clk or negedge IN_reset_n) begin
    if (!IN_reset_n) begin
      state    <= ENTER_A;
      num1     <= 16'd0;
      num2     <= 16'd0;
      op       <= 3'b000;
      cnt_a    <= 3'd0;
      cnt_b    <= 3'd0;
      rejected <= 1'b0;
    end else begin
      state    <= state_nxt;
      num1     <= num1_nxt;
      num2     <= num2_nxt;
      op       <= op_nxt;
      cnt_a    <= cnt_a_nxt;
      cnt_b    <= cnt_b_nxt;
      rejected <= rej_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    num1_nxt  = num1;
    num2_nxt  = num2;
    op_nxt    = op;
    cnt_a_nxt = cnt_a;
    cnt_b_nxt = cnt_b;
    rej_nxt   = 1'b0;
    is_digit  = (IN_key_code <= 4'd9);
    is_op     = (IN_key_code >= 4'd10) && (IN_key_code <= 4'd12);
    acc_a     = accumulate(num1, cnt_a, IN_key_code);
    acc_b     = accumulate(num2, cnt_b, IN_key_code);

    if (IN_key_valid && IN_key_code == KEY_CLEAR) begin
      state_nxt = ENTER_A;
      num1_nxt  = 16'd0;
      num2_nxt  = 16'd0;
      op_nxt    = 3'b000;
      cnt_a_nxt = 3'd0;
      cnt_b_nxt = 3'd0;
    end else begin
      case (state)
        ENTER_A: begin
          if (IN_key_valid) begin
            if (is_digit) begin
              if (acc_a.ok) begin
                num1_nxt  = acc_a.val;
                cnt_a_nxt = acc_a.cnt;
              end else begin
                rej_nxt = 1'b1;
              end
            end else if (IN_key_code == KEY_BKSP) begin
              if (cnt_a != 3'd0) begin
                num1_nxt  = num1 / 16'd10;
                cnt_a_nxt = cnt_a - 3'd1;
              end else begin
                rej_nxt = 1'b1;
              end
            end else if (is_op && cnt_a != 3'd0) begin
              op_nxt    = op_onehot(IN_key_code);
              num2_nxt  = 16'd0;
              cnt_b_nxt = 3'd0;
              state_nxt = ENTER_B;
            end else begin
              rej_nxt = 1'b1;
            end
          end
        end
        ENTER_B: begin
          if (IN_key_valid) begin
            if (is_digit) begin
              if (acc_b.ok) begin
                num2_nxt  = acc_b.val;
                cnt_b_nxt = acc_b.cnt;
              end else begin
                rej_nxt = 1'b1;
              end
            end else if (IN_key_code == KEY_BKSP) begin
              if (cnt_b != 3'd0) begin
                num2_nxt  = num2 / 16'd10;
                cnt_b_nxt = cnt_b - 3'd1;
              end else begin
                rej_nxt = 1'b1;
              end
            end else if (is_op && cnt_b == 3'd0) begin
              op_nxt = op_onehot(IN_key_code);
            end else if (IN_key_code == KEY_EQUALS && cnt_b != 3'd0) begin
              state_nxt = SHOW;
            end else begin
              rej_nxt = 1'b1;
            end
          end
        end
        SHOW: begin
          if (IN_key_valid) begin
            if (is_digit) begin
              num1_nxt  = {12'd0, IN_key_code};
              cnt_a_nxt = 3'd1;
              num2_nxt  = 16'd0;
              cnt_b_nxt = 3'd0;
              op_nxt    = 3'b000;
              state_nxt = ENTER_A;
            end else if (is_op && !IN_is_negative && IN_answer[31:16] == 16'd0) begin
              // Saturated digit count stops the chained answer from being extended with more digits.
              num1_nxt  = IN_answer[15:0];
              cnt_a_nxt = MAX_CNT;
              num2_nxt  = 16'd0;
              cnt_b_nxt = 3'd0;
              op_nxt    = op_onehot(IN_key_code);
              state_nxt = ENTER_B;
            end else begin
              rej_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = ENTER_A;
      endcase
    end
  end

  assign OUT_num1           = num1;
  assign OUT_num2           = num2;
  assign OUT_operation_code = op;
  assign OUT_show_answer    = (state == SHOW);
  assign OUT_entering_b     = (state == ENTER_B);
  assign OUT_key_rejected   = rejected;

endmodule

// File: tb/tb_calculator_entry_fsm.sv
// Self-checking bench for calculator_entry_fsm: a table of key vectors with hand-derived
// expected outputs, queued as a scoreboard and compared one cycle after each accepting edge.
module tb_calculator_entry_fsm;

  localparam logic [3:0] ADD = 4'd10, SUB = 4'd11, MUL = 4'd12;
  localparam logic [3:0] EQ = 4'd13, CLR = 4'd14, BS = 4'd15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] answer;
  logic        is_negative;
  logic [15:0] num1, num2;
  logic [2:0]  op_code;
  logic        show_answer, entering_b, key_rejected;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] num1;
    logic [15:0] num2;
    logic [2:0]  op;
    logic        show;
    logic        entb;
    logic        rej;
  } exp_t;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] ans;
    logic        neg;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  calculator_entry_fsm #(.MAX_DIGITS(5)) dut (
    .IN_clk             (clk),
    .IN_reset_n         (reset_n),
    .IN_key_valid       (key_valid),
    .IN_key_code        (key_code),
    .IN_answer          (answer),
    .IN_is_negative     (is_negative),
    .OUT_num1           (num1),
    .OUT_num2           (num2),
    .OUT_operation_code (op_code),
    .OUT_show_answer    (show_answer),
    .OUT_entering_b     (entering_b),
    .OUT_key_rejected   (key_rejected)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mk(input logic [15:0] n1, input logic [15:0] n2, input logic [2:0] op,
                              input logic show, input logic entb, input logic rej);
    exp_t e;
    e.num1 = n1; e.num2 = n2; e.op = op; e.show = show; e.entb = entb; e.rej = rej;
    return e;
  endfunction

  function automatic void v(input logic [3:0] key, input logic [31:0] ans, input logic neg,
                            input logic [15:0] n1, input logic [15:0] n2, input logic [2:0] op,
                            input logic show, input logic entb, input logic rej);
    vec_t r;
    r.key = key; r.ans = ans; r.neg = neg;
    r.exp = mk(n1, n2, op, show, entb, rej);
    vecs.push_back(r);
  endfunction

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard actual=empty required=entry", tag);
      return;
    end
    e = sb_q.pop_front();
    check_field({tag, " num1"}, 32'(num1), 32'(e.num1));
    check_field({tag, " num2"}, 32'(num2), 32'(e.num2));
    check_field({tag, " op"}, 32'(op_code), 32'(e.op));
    check_field({tag, " show"}, 32'(show_answer), 32'(e.show));
    check_field({tag, " entb"}, 32'(entering_b), 32'(e.entb));
    check_field({tag, " rej"}, 32'(key_rejected), 32'(e.rej));
  endtask

  // Called one time unit after a rising edge; result is sampled one unit after the next edge.
  task automatic apply_stimulus(input logic [3:0] key, input logic [31:0] ans, input logic neg,
                                input exp_t e, input string tag);
    key_valid   = 1'b1;
    key_code    = key;
    answer      = ans;
    is_negative = neg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    check_output(tag);
  endtask

  initial begin
    // test 1: basic entry
    v(1,   0, 0,   1,  0, 3'b000, 0, 0, 0);
    v(2,   0, 0,  12,  0, 3'b000, 0, 0, 0);
    v(3,   0, 0, 123,  0, 3'b000, 0, 0, 0);
    v(ADD, 0, 0, 123,  0, 3'b001, 0, 1, 0);
    v(4,   0, 0, 123,  4, 3'b001, 0, 1, 0);
    v(5,   0, 0, 123, 45, 3'b001, 0, 1, 0);
    v(EQ,  0, 0, 123, 45, 3'b001, 1, 0, 0);
    // test 4: chaining and chain rejects
    v(MUL, 300, 0, 300, 0, 3'b100, 0, 1, 0);
    v(7,     0, 0, 300, 7, 3'b100, 0, 1, 0);
    v(EQ,    0, 0, 300, 7, 3'b100, 1, 0, 0);
    v(MUL, 70000, 0, 300, 7, 3'b100, 1, 0, 1);
    v(MUL,     5, 1, 300, 7, 3'b100, 1, 0, 1);
    v(EQ,   2100, 0, 300, 7, 3'b100, 1, 0, 1);
    v(BS,   2100, 0, 300, 7, 3'b100, 1, 0, 1);
    // test 5: digit in SHOW restarts entry
    v(7,  2100, 0, 7, 0, 3'b000, 0, 0, 0);
    v(BS,    0, 0, 0, 0, 3'b000, 0, 0, 0);
    v(BS,    0, 0, 0, 0, 3'b000, 0, 0, 1);
    v(EQ,    0, 0, 0, 0, 3'b000, 0, 0, 1);
    v(ADD,   0, 0, 0, 0, 3'b000, 0, 0, 1);
    // leading zero handling
    v(0,  0, 0,  0, 0, 3'b000, 0, 0, 0);
    v(5,  0, 0,  5, 0, 3'b000, 0, 0, 0);
    v(1,  0, 0, 51, 0, 3'b000, 0, 0, 0);
    v(BS, 0, 0,  5, 0, 3'b000, 0, 0, 0);
    v(BS, 0, 0,  0, 0, 3'b000, 0, 0, 0);
    v(CLR, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    // test 2: 16-bit overflow boundary
    v(6, 0, 0,     6, 0, 3'b000, 0, 0, 0);
    v(5, 0, 0,    65, 0, 3'b000, 0, 0, 0);
    v(5, 0, 0,   655, 0, 3'b000, 0, 0, 0);
    v(3, 0, 0,  6553, 0, 3'b000, 0, 0, 0);
    v(5, 0, 0, 65535, 0, 3'b000, 0, 0, 0);
    v(6, 0, 0, 65535, 0, 3'b000, 0, 0, 1);
    v(CLR, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    v(6, 0, 0,     6, 0, 3'b000, 0, 0, 0);
    v(5, 0, 0,    65, 0, 3'b000, 0, 0, 0);
    v(5, 0, 0,   655, 0, 3'b000, 0, 0, 0);
    v(3, 0, 0,  6553, 0, 3'b000, 0, 0, 0);
    v(6, 0, 0,  6553, 0, 3'b000, 0, 0, 1);
    v(CLR, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    // test 3: operator replacement and backspace in ENTER_B
    v(9,   0, 0, 9, 0, 3'b000, 0, 0, 0);
    v(SUB, 0, 0, 9, 0, 3'b010, 0, 1, 0);
    v(MUL, 0, 0, 9, 0, 3'b100, 0, 1, 0);
    v(3,   0, 0, 9, 3, 3'b100, 0, 1, 0);
    v(BS,  0, 0, 9, 0, 3'b100, 0, 1, 0);
    v(BS,  0, 0, 9, 0, 3'b100, 0, 1, 1);
    v(EQ,  0, 0, 9, 0, 3'b100, 0, 1, 1);
    v(ADD, 0, 0, 9, 0, 3'b001, 0, 1, 0);
    v(2,   0, 0, 9, 2, 3'b001, 0, 1, 0);
    v(ADD, 0, 0, 9, 2, 3'b001, 0, 1, 1);
    v(EQ,  0, 0, 9, 2, 3'b001, 1, 0, 0);
    // chaining a zero answer, then backspace cannot leave ENTER_B
    v(ADD, 0, 0, 0, 0, 3'b001, 0, 1, 0);
    v(5,   0, 0, 0, 5, 3'b001, 0, 1, 0);
    v(BS,  0, 0, 0, 0, 3'b001, 0, 1, 0);
    v(BS,  0, 0, 0, 0, 3'b001, 0, 1, 1);
    // clear from ENTER_B with num1=12
    v(CLR, 0, 0,  0, 0, 3'b000, 0, 0, 0);
    v(1,   0, 0,  1, 0, 3'b000, 0, 0, 0);
    v(2,   0, 0, 12, 0, 3'b000, 0, 0, 0);
    v(ADD, 0, 0, 12, 0, 3'b001, 0, 1, 0);
    v(3,   0, 0, 12, 3, 3'b001, 0, 1, 0);
    v(CLR, 0, 0,  0, 0, 3'b000, 0, 0, 0);
    // chain answer boundary 65535 / 65536
    v(1,   0, 0, 1, 0, 3'b000, 0, 0, 0);
    v(ADD, 0, 0, 1, 0, 3'b001, 0, 1, 0);
    v(1,   0, 0, 1, 1, 3'b001, 0, 1, 0);
    v(EQ,  0, 0, 1, 1, 3'b001, 1, 0, 0);
    v(SUB, 65536, 0,     1, 1, 3'b001, 1, 0, 1);
    v(SUB, 65535, 0, 65535, 0, 3'b010, 0, 1, 0);
    v(CLR, 0, 0, 0, 0, 3'b000, 0, 0, 0);

    reset_n     = 1'b0;
    key_valid   = 1'b0;
    key_code    = 4'd0;
    answer      = 32'd0;
    is_negative = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_field("reset num1", 32'(num1), 32'd0);
    check_field("reset num2", 32'(num2), 32'd0);
    check_field("reset op", 32'(op_code), 32'd0);
    check_field("reset show", 32'(show_answer), 32'd0);
    check_field("reset entb", 32'(entering_b), 32'd0);
    check_field("reset rej", 32'(key_rejected), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].key, vecs[i].ans, vecs[i].neg, vecs[i].exp, $sformatf("vec%0d", i));

    // idle cycle: key_code changes with valid low, nothing may happen
    apply_stimulus(4'd8, 0, 0, mk(8, 0, 3'b000, 0, 0, 0), "pre_idle");
    key_code = 4'd9;
    sb_q.push_back(mk(8, 0, 3'b000, 0, 0, 0));
    @(posedge clk);
    #1;
    check_output("idle");

    // asynchronous reset in the middle of a cycle while in ENTER_B
    apply_stimulus(ADD, 0, 0, mk(8, 0, 3'b001, 0, 1, 0), "pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check_field("async num1", 32'(num1), 32'd0);
    check_field("async op", 32'(op_code), 32'd0);
    check_field("async entb", 32'(entering_b), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // valid held high for three cycles is three separate keys
    apply_stimulus(4'd4, 0, 0, mk(4,   0, 3'b000, 0, 0, 0), "held1");
    apply_stimulus(4'd4, 0, 0, mk(44,  0, 3'b000, 0, 0, 0), "held2");
    apply_stimulus(4'd4, 0, 0, mk(444, 0, 3'b000, 0, 0, 0), "held3");

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
